// File: rtl/wb_frame_reader.sv
// Wishbone classic read master that fetches one frame (32-bit header + ROWS*COLS 8-bit pixels) and streams pixels out.
// Latency: start -> header strobe 1 cycle, first pixel valid 3 cycles after start with zero-wait ack.
// Backpressure: o_vld/i_rdy handshake; output byte and flags hold while stalled, no bus read is issued until the buffered word drains.
module wb_frame_reader #(
   parameter int ADR_WIDTH = 15,
   parameter int ROWS      = 120,
   parameter int COLS      = 160
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [ADR_WIDTH-1:0] rd_addr_start,
   output logic [31:0]          o_timestamp,
   output logic                 o_ts_vld,
   output logic [7:0]           o_dat,
   output logic                 o_vld,
   input  logic                 i_rdy,
   output logic                 o_sof,
   output logic                 o_eol,
   output logic                 o_eof,
   output logic                 busy,
   output logic                 done,
   output logic                 m_wb_cyc,
   output logic                 m_wb_stb,
   output logic [ADR_WIDTH-1:0] m_wb_adr,
   output logic                 m_wb_we,
   input  logic [31:0]          m_i_wb_dat,
   input  logic                 m_wb_ack
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RD_TS = 2'd1,
      RD_PX = 2'd2,
      EMIT  = 2'd3
   } state_t;

   state_t               state_q;
   logic [ADR_WIDTH-1:0] adr_q;
   logic                 cyc_q;
   logic [31:0]          ts_q;
   logic                 ts_vld_q;
   logic [31:0]          buf_q;
   logic [1:0]           idx_q;
   logic [ROW_W-1:0]     row_q;
   logic [COL_W-1:0]     col_q;
   logic [7:0]           dat_q;
   logic                 vld_q;
   logic [2:0]           flags_q;   // {sof, eol, eof}
   logic                 done_q;

   // Next pixel position, next byte of the buffered word, and end-of-frame detect
   logic [ROW_W-1:0]     row_d;
   logic [COL_W-1:0]     col_d;
   logic [1:0]           idx_d;
   logic [7:0]           byte_d;
   logic                 col_last_d;
   logic                 frame_last_d;
   logic                 xfer_d;

   // Flags for the pixel at a given raster position
   function automatic logic [2:0] flags_at(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
      logic sof;
      logic eol;
      logic eof;
      sof = (r == '0) && (c == '0);
      eol = (c == COL_W'(COLS - 1));
      eof = eol && (r == ROW_W'(ROWS - 1));
      return {sof, eol, eof};
   endfunction

   // Raster advance and byte selection for the pixel that follows the current one
   always_comb begin
      col_last_d   = (col_q == COL_W'(COLS - 1));
      frame_last_d = col_last_d && (row_q == ROW_W'(ROWS - 1));
      col_d        = col_last_d ? '0 : col_q + COL_W'(1);
      row_d        = col_last_d ? row_q + ROW_W'(1) : row_q;
      idx_d        = idx_q + 2'd1;
      byte_d       = buf_q[{idx_d, 3'b000} +: 8];
      xfer_d       = vld_q && i_rdy;
   end

   // Frame sequencer: bus handshake, pixel emission and all registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         adr_q    <= '0;
         cyc_q    <= 1'b0;
         ts_q     <= '0;
         ts_vld_q <= 1'b0;
         buf_q    <= '0;
         idx_q    <= '0;
         row_q    <= '0;
         col_q    <= '0;
         dat_q    <= '0;
         vld_q    <= 1'b0;
         flags_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         ts_vld_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  adr_q   <= rd_addr_start;
                  row_q   <= '0;
                  col_q   <= '0;
                  idx_q   <= '0;
                  cyc_q   <= 1'b1;
                  state_q <= RD_TS;
               end
            end
            RD_TS: begin
               // Abort wins over a same-cycle ack; the header register keeps its old value
               if (abort) begin
                  cyc_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (m_wb_ack) begin
                  ts_q     <= m_i_wb_dat;
                  ts_vld_q <= 1'b1;
                  adr_q    <= adr_q + ADR_WIDTH'(4);
                  state_q  <= RD_PX;
               end
            end
            RD_PX: begin
               if (abort) begin
                  cyc_q   <= 1'b0;
                  state_q <= IDLE;
               end else if (m_wb_ack) begin
                  buf_q   <= m_i_wb_dat;
                  idx_q   <= '0;
                  adr_q   <= adr_q + ADR_WIDTH'(4);
                  cyc_q   <= 1'b0;
                  dat_q   <= m_i_wb_dat[7:0];
                  vld_q   <= 1'b1;
                  flags_q <= flags_at(row_q, col_q);
                  state_q <= EMIT;
               end
            end
            EMIT: begin
               if (abort) begin
                  vld_q   <= 1'b0;
                  flags_q <= '0;
                  state_q <= IDLE;
               end else if (xfer_d) begin
                  col_q <= col_d;
                  row_q <= row_d;
                  if (idx_q == 2'd3) begin
                     // Word drained: fetch the next one, or finish if this was the last pixel
                     vld_q   <= 1'b0;
                     flags_q <= '0;
                     if (frame_last_d) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                     end else begin
                        cyc_q   <= 1'b1;
                        state_q <= RD_PX;
                     end
                  end else begin
                     // COLS is a multiple of 4, so a line never ends inside a word before byte 3
                     idx_q   <= idx_d;
                     dat_q   <= byte_d;
                     flags_q <= flags_at(row_d, col_d);
                  end
               end
            end
            default: begin
               cyc_q   <= 1'b0;
               vld_q   <= 1'b0;
               flags_q <= '0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m_wb_cyc    = cyc_q;
   assign m_wb_stb    = cyc_q;
   assign m_wb_we     = 1'b0;
   assign m_wb_adr    = adr_q;
   assign o_timestamp = ts_q;
   assign o_ts_vld    = ts_vld_q;
   assign o_dat       = dat_q;
   assign o_vld       = vld_q;
   assign o_sof       = flags_q[2];
   assign o_eol       = flags_q[1];
   assign o_eof       = flags_q[0];
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

endmodule
